netdma_rx_framer: RTL

NETDMA_RX_FRAMER -- requirements
Module: netdma_rx_framer

---
 rtl/netdma_rx_framer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/netdma_rx_framer.sv
// netdma_rx_framer: Avalon-ST framing sanitiser ahead of the st2mm write master; stats behind NETDMA_RX_FRAMER_STATS_EN.
// Latency: 2 cycles for an eop beat; non-eop beats wait in lookahead H until the next beat arrives.
// Backpressure: in_ready low only when H and O are both full and O is stalled by out_ready.
module netdma_rx_framer #(
    parameter int DATA_WIDTH    = 64,
    parameter int MAX_PKT_BYTES = 9600
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_startofpacket,
    input  logic                            in_endofpacket,
    input  logic                            in_error,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] in_empty,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_startofpacket,
    output logic                            out_endofpacket,
    output logic                            out_error,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [$clog2(DATA_WIDTH/8)-1:0] out_empty,
    input  logic                            stat_clr,
    output logic [31:0]                     stat_pkt_cnt,
    output logic [31:0]                     stat_err_cnt,
    output logic [31:0]                     stat_drop_cnt
);
    localparam int          EMPTY_WIDTH = $clog2(DATA_WIDTH/8);
    localparam int          BEAT_BYTES  = DATA_WIDTH/8;
    localparam logic [16:0] MAX_BYTES   = 17'(MAX_PKT_BYTES);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  dat;
        logic [EMPTY_WIDTH-1:0] empty;
        logic                   sop;
        logic                   eop;
        logic                   err;
    } beat_t;

    typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DISCARD} state_t;

    state_t      state_q, state_d;
    logic        h_vld_q, h_vld_d;
    beat_t       h_q, h_d;
    logic        o_vld_q, o_vld_d;
    beat_t       o_q, o_d;
    logic [16:0] cnt_q, cnt_d;
    logic        err_acc_q, err_acc_d;
    logic        rdy_en_q, rdy_en_d;

    logic        out_xfer, o_free, in_fire;
    logic        accept_new, terminate_h, drop_inc, h_to_o, overflow;
    logic [16:0] beat_bytes, cnt_sum;
    beat_t       in_beat, h_term;

    // rdy_en_q keeps in_ready low through reset and for the cycle it is released in.
    assign rdy_en_d   = 1'b1;
    assign out_xfer   = o_vld_q & out_ready;
    assign o_free     = ~o_vld_q | out_xfer;
    assign in_ready   = rdy_en_q & (~h_vld_q | o_free);
    assign in_fire    = in_valid & in_ready;
    assign beat_bytes = 17'(BEAT_BYTES) - (in_endofpacket ? 17'(in_empty) : 17'd0);
    assign cnt_sum    = cnt_q + beat_bytes;
    assign overflow   = cnt_sum > MAX_BYTES;

    // Only eop beats carry error/empty; error is the sticky OR across the whole packet.
    always_comb begin
        in_beat.dat   = in_data;
        in_beat.sop   = in_startofpacket;
        in_beat.eop   = in_endofpacket;
        in_beat.empty = in_endofpacket ? in_empty : '0;
        in_beat.err   = in_endofpacket & (in_error | (err_acc_q & ~in_startofpacket));
        h_term        = h_q;
        h_term.eop    = 1'b1;
        h_term.err    = 1'b1;
        h_term.empty  = '0;
    end

    always_comb begin
        state_d     = state_q;
        h_vld_d     = h_vld_q;
        h_d         = h_q;
        o_vld_d     = o_vld_q;
        o_d         = o_q;
        cnt_d       = cnt_q;
        err_acc_d   = err_acc_q;
        accept_new  = 1'b0;
        terminate_h = 1'b0;
        drop_inc    = 1'b0;
        if (in_fire) begin
            case (state_q)
                ST_PKT: begin
                    if (in_startofpacket) begin
                        terminate_h = 1'b1;
                        accept_new  = 1'b1;
                    end else if (overflow) begin
                        // Oversize: close the packet on the beat already held, drop the rest.
                        terminate_h = 1'b1;
                        drop_inc    = 1'b1;
                        state_d     = in_endofpacket ? ST_IDLE : ST_DISCARD;
                    end else begin
                        accept_new = 1'b1;
                    end
                end
                default: begin
                    if (in_startofpacket) begin
                        accept_new = 1'b1;
                    end else begin
                        drop_inc = (state_q == ST_IDLE);
                        if (in_endofpacket) state_d = ST_IDLE;
                    end
                end
            endcase
            if (accept_new) begin
                state_d   = in_endofpacket ? ST_IDLE : ST_PKT;
                cnt_d     = in_startofpacket ? beat_bytes : cnt_sum;
                err_acc_d = in_error | (err_acc_q & ~in_startofpacket);
            end
        end

        // While in PKT, H always holds the newest beat, so any accepted beat can displace it.
        h_to_o = h_vld_q & o_free & (in_fire | h_q.eop);
        if (h_to_o) begin
            o_vld_d = 1'b1;
            o_d     = terminate_h ? h_term : h_q;
        end else if (out_xfer) begin
            o_vld_d = 1'b0;
        end
        if (accept_new) begin
            h_vld_d = 1'b1;
            h_d     = in_beat;
        end else if (h_to_o) begin
            h_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            h_vld_q   <= 1'b0;
            h_q       <= '0;
            o_vld_q   <= 1'b0;
            o_q       <= '0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_vld_q   <= h_vld_d;
            h_q       <= h_d;
            o_vld_q   <= o_vld_d;
            o_q       <= o_d;
            cnt_q     <= cnt_d;
            err_acc_q <= err_acc_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

    assign out_valid         = o_vld_q;
    assign out_startofpacket = o_q.sop;
    assign out_endofpacket   = o_q.eop;
    assign out_error         = o_q.err;
    assign out_data          = o_q.dat;
    assign out_empty         = o_q.empty;

`ifdef NETDMA_RX_FRAMER_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        eop_xfer;

    assign eop_xfer = out_xfer & o_q.eop;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q + {31'd0, eop_xfer};
        err_cnt_d  = err_cnt_q + {31'd0, eop_xfer & o_q.err};
        drop_cnt_d = drop_cnt_q + {31'd0, drop_inc};
        if (stat_clr) begin
            pkt_cnt_d  = '0;
            err_cnt_d  = '0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_err_cnt  = err_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats  = stat_clr | drop_inc;
    assign stat_pkt_cnt  = '0;
    assign stat_err_cnt  = '0;
    assign stat_drop_cnt = '0;
`endif

endmodule
